// File: rtl/seq_div.sv
// seq_div: multi-cycle restoring radix-2 divider, signed or unsigned,
// with a valid/ready request side and a valid/ready result side.
//
// state | meaning
// IDLE  | waiting for an operation; op_rdy high
// RUN   | one restoring step per cycle on the operand magnitudes, W cycles
// FIX   | apply result signs and latch quot/rem
// DONE  | result held; res_vld rises one cycle after entry, until res_rdy
module seq_div #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         op_vld,
    output logic         op_rdy,
    input  logic         op_signed,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    input  logic         flush,
    output logic         res_vld,
    input  logic         res_rdy,
    output logic [W-1:0] quot,
    output logic [W-1:0] rem
);

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t         r_state;
    state_t         w_next;
    logic [CW-1:0]  r_cnt;
    logic           r_signed;
    logic           r_neg_q;
    logic           r_neg_r;
    logic [W-1:0]   r_q;
    logic [W-1:0]   r_part;
    logic [W-1:0]   r_dvs;
    logic [W-1:0]   r_quot;
    logic [W-1:0]   r_rem;
    logic           r_res_vld;

    logic           w_accept;
    logic [W-1:0]   w_a_abs;
    logic [W-1:0]   w_b_abs;
    logic [W:0]     w_shift;
    logic [W:0]     w_diff;

    assign w_accept = (r_state == IDLE) && op_vld && !flush;
    assign w_a_abs  = (op_signed && dividend[W-1]) ? (~dividend + W'(1)) : dividend;
    assign w_b_abs  = (op_signed && divisor[W-1])  ? (~divisor + W'(1))  : divisor;
    assign w_shift  = {r_part, r_q[W-1]};
    assign w_diff   = w_shift - {1'b0, r_dvs};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic; flush overrides every transition
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (op_vld)                w_next = RUN;
            RUN:  if (r_cnt == LAST_STEP)    w_next = FIX;
            FIX:                             w_next = DONE;
            DONE: if (r_res_vld && res_rdy)  w_next = IDLE;
            default:                         w_next = IDLE;
        endcase
        if (flush) w_next = IDLE;
    end

    // FSM outputs
    always_comb begin
        op_rdy  = (r_state == IDLE);
        res_vld = r_res_vld;
        quot    = r_quot;
        rem     = r_rem;
    end

    // Step counter: counts RUN cycles, back to 0 whenever RUN is left
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                      r_cnt <= '0;
        else if (flush || r_state != RUN || r_cnt == LAST_STEP) r_cnt <= '0;
        else                                             r_cnt <= r_cnt + CW'(1);
    end

    // Operand capture and restoring iteration
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_signed <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_q      <= '0;
            r_part   <= '0;
            r_dvs    <= '0;
        end else if (w_accept) begin
            r_signed <= op_signed;
            // A zero divisor must yield all ones, so the quotient is never negated.
            r_neg_q  <= op_signed && (dividend[W-1] ^ divisor[W-1]) && (divisor != '0);
            r_neg_r  <= op_signed && dividend[W-1];
            r_q      <= w_a_abs;
            r_part   <= '0;
            r_dvs    <= w_b_abs;
        end else if (r_state == RUN && !flush) begin
            if (!w_diff[W]) begin
                r_part <= w_diff[W-1:0];
                r_q    <= {r_q[W-2:0], 1'b1};
            end else begin
                r_part <= w_shift[W-1:0];
                r_q    <= {r_q[W-2:0], 1'b0};
            end
        end
    end

    // Sign fix-up into the result registers, and result-valid handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_quot    <= '0;
            r_rem     <= '0;
            r_res_vld <= 1'b0;
        end else if (flush) begin
            r_res_vld <= 1'b0;
        end else begin
            if (r_state == FIX) begin
                r_quot <= (r_signed && r_neg_q) ? (~r_q + W'(1))    : r_q;
                r_rem  <= (r_signed && r_neg_r) ? (~r_part + W'(1)) : r_part;
            end
            if (r_state == DONE && !r_res_vld)   r_res_vld <= 1'b1;
            else if (r_res_vld && res_rdy)       r_res_vld <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seq_div.sv
// Directed bench for seq_div (W=32) with hand-computed expected results.
module tb_seq_div;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        op_vld = 1'b0;
    logic        op_rdy;
    logic        op_signed = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        flush = 1'b0;
    logic        res_vld;
    logic        res_rdy = 1'b0;
    logic [31:0] quot;
    logic [31:0] rem;

    int total = 0;
    int bad = 0;
    int lat;
    logic [31:0] q_hold, r_hold;
    logic seen;

    seq_div #(.W(32)) dut (
        .clk(clk), .rst_n(rst_n), .op_vld(op_vld), .op_rdy(op_rdy),
        .op_signed(op_signed), .dividend(dividend), .divisor(divisor),
        .flush(flush), .res_vld(res_vld), .res_rdy(res_rdy),
        .quot(quot), .rem(rem)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present an operation for exactly one edge, then scramble the inputs.
    task automatic start_op(input logic s, input logic [31:0] a, input logic [31:0] b);
        op_signed = s; dividend = a; divisor = b; op_vld = 1'b1;
        @(posedge clk); #1;
        op_vld = 1'b0; op_signed = ~s; dividend = 32'hDEAD_BEEF; divisor = 32'h0;
    endtask

    task automatic wait_res(output int n);
        n = 0;
        while (!res_vld && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic take_res();
        res_rdy = 1'b1;
        @(posedge clk); #1;
        res_rdy = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic s, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er);
        chk({tag, " op_rdy before"}, {31'b0, op_rdy}, 32'd1);
        start_op(s, a, b);
        wait_res(lat);
        chk({tag, " latency"}, lat, 32'd34);
        chk({tag, " quot"}, quot, eq);
        chk({tag, " rem"}, rem, er);
        take_res();
        chk({tag, " op_rdy after"}, {31'b0, op_rdy}, 32'd1);
        chk({tag, " res_vld after"}, {31'b0, res_vld}, 32'd0);
    endtask

    initial begin
        #2;
        chk("reset op_rdy", {31'b0, op_rdy}, 32'd1);
        chk("reset res_vld", {31'b0, res_vld}, 32'd0);
        chk("reset quot", quot, 32'd0);
        chk("reset rem", rem, 32'd0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("u100/7",   1'b0, 32'd100,        32'd7,        32'd14,         32'd2);
        run_op("s-7/2",    1'b1, 32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFD,  32'hFFFF_FFFF);
        run_op("u-7/2",    1'b0, 32'hFFFF_FFF9,  32'd2,        32'h7FFF_FFFC,  32'd1);
        run_op("s100/-7",  1'b1, 32'd100,        32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2);
        run_op("s0x1234/0", 1'b1, 32'h1234,      32'd0,        32'hFFFF_FFFF,  32'h1234);
        run_op("u0x1234/0", 1'b0, 32'h1234,      32'd0,        32'hFFFF_FFFF,  32'h1234);
        run_op("s-7/0",    1'b1, 32'hFFFF_FFF9,  32'd0,        32'hFFFF_FFFF,  32'hFFFF_FFF9);
        run_op("s_ovf",    1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 32'd0);

        // Backpressure: 1000 / 33 = 30 rem 10, held for 5 cycles
        start_op(1'b0, 32'd1000, 32'd33);
        wait_res(lat);
        chk("bp latency", lat, 32'd34);
        chk("bp quot", quot, 32'd30);
        chk("bp rem", rem, 32'd10);
        q_hold = quot; r_hold = rem;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp hold quot", quot, q_hold);
            chk("bp hold rem", rem, r_hold);
            chk("bp hold res_vld", {31'b0, res_vld}, 32'd1);
            chk("bp op_rdy low", {31'b0, op_rdy}, 32'd0);
        end
        res_rdy = 1'b1;
        #1;
        chk("bp op_rdy before edge", {31'b0, op_rdy}, 32'd0);
        @(posedge clk); #1;
        res_rdy = 1'b0;
        chk("bp op_rdy after", {31'b0, op_rdy}, 32'd1);
        chk("bp res_vld after", {31'b0, res_vld}, 32'd0);

        // Flush during the 10th RUN cycle
        start_op(1'b0, 32'd500, 32'd3);
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush op_rdy", {31'b0, op_rdy}, 32'd1);
        chk("flush res_vld", {31'b0, res_vld}, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (res_vld) seen = 1'b1;
        end
        chk("flush no result", {31'b0, seen}, 32'd0);

        // Flush outranks res_rdy while a result is pending
        start_op(1'b0, 32'd9, 32'd4);
        wait_res(lat);
        chk("flush2 quot", quot, 32'd2);
        flush = 1'b1; res_rdy = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; res_rdy = 1'b0;
        chk("flush2 res_vld", {31'b0, res_vld}, 32'd0);
        chk("flush2 op_rdy", {31'b0, op_rdy}, 32'd1);

        // Asynchronous reset mid-RUN (quot/rem currently nonzero)
        start_op(1'b0, 32'd77, 32'd5);
        repeat (5) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        chk("arst op_rdy", {31'b0, op_rdy}, 32'd1);
        chk("arst res_vld", {31'b0, res_vld}, 32'd0);
        chk("arst quot", quot, 32'd0);
        chk("arst rem", rem, 32'd0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("post-reset 77/5", 1'b0, 32'd77, 32'd5, 32'd15, 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
